sevenseg_scan_ctrl: RTL

- Time-multiplexing controller for the board's common-anode seven-segment display bank.
- Sequences NUM_DIGITS digits through one shared hex-to-segment decoder.
- Drives active-low anodes, segments and decimal point, with an anti-ghosting blank gap at each digit switch.
- Holds a double-buffered display value. A new value is accepted at any time but only shown from the next frame boundary, so frames never tear.

---
 rtl/sevenseg_scan_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for a common-anode seven-segment bank. One decoder is shared
// by all digits, with a blank gap at each digit switch and a double-buffered value.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lz_en,
  output logic [NUM_DIGITS-1:0]         an_L,
  output logic [6:0]                    seg_L,
  output logic                          dp_L,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick,
  output logic                          upd_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4*NUM_DIGITS;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES-1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS-1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  act_lz_q, act_lz_d, pend_lz_q, pend_lz_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  tick_q, tick_d;
  logic                  upd_q, upd_d;

  logic                  slot_wrap, boundary, on_phase, transfer;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    case (v)
      4'h0: hex2seg = 7'h40;  4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;  4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;  4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;  4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;  4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;  default: hex2seg = 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero when it and every nibble above it are zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = act_val_q[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = act_lz_q && (act_val_q[VW-1:4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    slot_wrap = (cnt_q == SLOT_LAST);
    boundary  = en && slot_wrap && (idx_q == IDX_LAST);
    on_phase  = en && (cnt_q >= BLANK_END);

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (slot_wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_lz_d     = act_lz_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_lz_d    = pend_lz_q;
    pend_valid_d = pend_valid_q;
    transfer     = pend_valid_q && (boundary || !en);
    upd_d        = transfer;
    if (transfer) begin
      act_val_d    = pend_val_q;
      act_dp_d     = pend_dp_q;
      act_lz_d     = pend_lz_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_in;
      pend_lz_d    = lz_en;
      pend_valid_d = 1'b1;
      // While stopped there is no frame to protect, so the load goes straight live.
      if (!en) begin
        act_val_d    = value_in;
        act_dp_d     = dp_in;
        act_lz_d     = lz_en;
        pend_valid_d = 1'b0;
        upd_d        = 1'b1;
      end
    end

    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    tick_d = boundary;
    if (on_phase) begin
      an_d[idx_q] = 1'b0;
      seg_d       = lz_blank[idx_q] ? 7'h7F : hex2seg(nib[idx_q]);
      dp_d        = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_lz_q     <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_lz_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      tick_q       <= 1'b0;
      upd_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_lz_q     <= act_lz_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      tick_q       <= tick_d;
      upd_q        <= upd_d;
    end
  end

  assign an_L       = an_q;
  assign seg_L      = seg_q;
  assign dp_L       = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;
  assign upd_done   = upd_q;

endmodule
